// File: rtl/scr1_sub_trace_buf.sv
// scr1_sub_trace_buf
// Snoops the IFU->IDU instruction handshake. Each accepted SUB
// (R-type, funct3=000, funct7=0100000) captures a snapshot of
// {pc, mstatus, mtvec, mcycle} into a DEPTH-entry FIFO. A valid/ready
// port streams each snapshot out as five 32-bit words.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   instr_vld/instr_rdy IFU->IDU handshake being observed
//   instr, pc           instruction word and its pc
//   csr_mstatus/mtvec   CSR values sampled on capture
//   csr_mcycle          64-bit cycle counter sampled on capture
//   rd_vld/rd_rdy       readout handshake
//   rd_data             current word: 0=pc 1=mstatus 2=mtvec 3=mcycle lo 4=mcycle hi
//   rd_idx, rd_last     word index within record, high on word 4
//   rec_cnt             records currently stored
//   drop_cnt            records lost to a full buffer, saturating at 8'hFF
module scr1_sub_trace_buf #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     instr_vld,
   input  logic                     instr_rdy,
   input  logic [31:0]              instr,
   input  logic [31:0]              pc,
   input  logic [31:0]              csr_mstatus,
   input  logic [31:0]              csr_mtvec,
   input  logic [63:0]              csr_mcycle,
   output logic                     rd_vld,
   input  logic                     rd_rdy,
   output logic [31:0]              rd_data,
   output logic [2:0]               rd_idx,
   output logic                     rd_last,
   output logic [$clog2(DEPTH):0]   rec_cnt,
   output logic [7:0]               drop_cnt
);

   localparam int                 AW      = $clog2(DEPTH);
   localparam int                 PTR_W   = AW + 1;
   localparam logic [PTR_W-1:0]   DEPTH_P = PTR_W'(DEPTH);
   localparam logic [2:0]         LAST_W  = 3'd4;

   typedef enum logic {ST_IDLE, ST_SEND} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   head_q, head_d;
   logic [PTR_W-1:0]   tail_q, tail_d;
   logic [2:0]         idx_q, idx_d;
   logic [7:0]         drop_q, drop_d;

   // Word 0 of a record sits in element [0].
   logic [4:0][31:0]   rec_mem_q [DEPTH];

   logic               match;
   logic               pop;
   logic               push;
   logic               full;
   logic [PTR_W-1:0]   cnt_q;
   logic [PTR_W-1:0]   cnt_d;

   // Instruction fields that play no part in the SUB decode.
   logic               unused_instr;
   assign unused_instr = ^{instr[24:15], instr[11:7]};

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      match   = instr_vld & instr_rdy
              & (instr[6:0]   == 7'b0110011)
              & (instr[14:12] == 3'b000)
              & (instr[31:25] == 7'b0100000);

      cnt_q   = tail_q - head_q;
      full    = (cnt_q == DEPTH_P);
      rd_vld  = (state_q == ST_SEND);
      pop     = rd_vld & rd_rdy & (idx_q == LAST_W);
      // A pop of word 4 frees the head slot on the same edge, so a full
      // buffer can still accept the incoming record.
      push    = match & (~full | pop);

      head_d  = head_q;
      tail_d  = tail_q;
      idx_d   = idx_q;
      drop_d  = drop_q;

      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;

      if (rd_vld & rd_rdy) idx_d = pop ? 3'd0 : idx_q + 3'd1;

      if (match & ~push & (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;

      // Moving to SEND on the capture edge gives a one-cycle capture-to-word latency.
      cnt_d   = tail_d - head_d;
      state_d = (cnt_d != '0) ? ST_SEND : ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         head_q  <= '0;
         tail_q  <= '0;
         idx_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         idx_q   <= idx_d;
         drop_q  <= drop_d;
      end
   end

   // NOTE: record storage is not reset; the pointers alone decide which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         rec_mem_q[tail_q[AW-1:0]] <= {csr_mcycle[63:32], csr_mcycle[31:0],
                                       csr_mtvec, csr_mstatus, pc};
      end
   end

   assign rd_data  = rd_vld ? rec_mem_q[head_q[AW-1:0]][idx_q] : 32'h0;
   assign rd_idx   = idx_q;
   assign rd_last  = rd_vld & (idx_q == LAST_W);
   assign rec_cnt  = cnt_q;
   assign drop_cnt = drop_q;

endmodule

// File: tb/tb_scr1_sub_trace_buf.sv
// Directed bench for scr1_sub_trace_buf (DEPTH=4). Inputs change 1 ns
// after the rising edge; outputs are compared at that same point.
module tb_scr1_sub_trace_buf;

   localparam logic [31:0] SUB_A0 = 32'h40B50533;
   localparam logic [31:0] ADD_A0 = 32'h00B50533;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        instr_vld = 1'b0;
   logic        instr_rdy = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic [31:0] csr_mstatus = '0;
   logic [31:0] csr_mtvec = '0;
   logic [63:0] csr_mcycle = '0;
   logic        rd_vld;
   logic        rd_rdy = 1'b0;
   logic [31:0] rd_data;
   logic [2:0]  rd_idx;
   logic        rd_last;
   logic [2:0]  rec_cnt;
   logic [7:0]  drop_cnt;

   int n_vec = 0;
   int n_err = 0;

   scr1_sub_trace_buf #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_vld   (instr_vld),
      .instr_rdy   (instr_rdy),
      .instr       (instr),
      .pc          (pc),
      .csr_mstatus (csr_mstatus),
      .csr_mtvec   (csr_mtvec),
      .csr_mcycle  (csr_mcycle),
      .rd_vld      (rd_vld),
      .rd_rdy      (rd_rdy),
      .rd_data     (rd_data),
      .rd_idx      (rd_idx),
      .rd_last     (rd_last),
      .rec_cnt     (rec_cnt),
      .drop_cnt    (drop_cnt)
   );

   always #5 clk = ~clk;

   // Record contents derived from a key (the pc); word i of that record.
   function automatic logic [31:0] kw(input logic [31:0] key, input int i);
      case (i)
         0:       kw = key;
         1:       kw = key ^ 32'h0000_1880;
         2:       kw = key + 32'h0000_01C0;
         3:       kw = key * 3;
         default: kw = ~key;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_sub(input logic [31:0] p, input logic [31:0] ms,
                          input logic [31:0] mt, input logic [63:0] mc);
      instr_vld   = 1'b1;
      instr_rdy   = 1'b1;
      instr       = SUB_A0;
      pc          = p;
      csr_mstatus = ms;
      csr_mtvec   = mt;
      csr_mcycle  = mc;
   endtask

   task automatic bus_key(input logic [31:0] key);
      bus_sub(key, kw(key, 1), kw(key, 2), {kw(key, 4), kw(key, 3)});
   endtask

   task automatic bus_idle();
      instr_vld = 1'b0;
      instr     = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_vec++;
      if (rd_vld !== 1'b0 || rd_data !== 32'h0 || rd_idx !== 3'd0 ||
          rd_last !== 1'b0 || rec_cnt !== 3'd0 || drop_cnt !== 8'd0) begin
         n_err++;
         $display("FAIL reset: vld=%b data=%h idx=%0d last=%b cnt=%0d drop=%0d, required all zero",
                  rd_vld, rd_data, rd_idx, rd_last, rec_cnt, drop_cnt);
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      logic [31:0] exp_w [5];
      exp_w = '{32'h200, 32'h1880, 32'h1C0, 32'h10, 32'h1};
      rd_rdy = 1'b1;
      bus_sub(32'h200, 32'h1880, 32'h1C0, 64'h0000_0001_0000_0010);
      n_vec++;
      if (rd_vld !== 1'b0) begin
         n_err++;
         $display("FAIL single_pre: vld=%b, required 0", rd_vld);
      end
      tick();
      bus_idle();
      n_vec++;
      if (rec_cnt !== 3'd1) begin
         n_err++;
         $display("FAIL single_cnt: rec_cnt=%0d, required 1", rec_cnt);
      end
      for (int w = 0; w < 5; w++) begin
         n_vec++;
         if (rd_vld !== 1'b1 || rd_data !== exp_w[w] || rd_idx !== w[2:0] || rd_last !== (w == 4)) begin
            n_err++;
            $display("FAIL single_w%0d: vld=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                     w, rd_vld, rd_data, rd_idx, rd_last, exp_w[w], w, (w == 4));
         end
         tick();
      end
      n_vec++;
      if (rd_vld !== 1'b0 || rec_cnt !== 3'd0 || rd_data !== 32'h0) begin
         n_err++;
         $display("FAIL single_post: vld=%b cnt=%0d data=%h, required 0 0 0", rd_vld, rec_cnt, rd_data);
      end
   endtask

   task automatic test_nomatch();
      rd_rdy = 1'b1;
      for (int c = 0; c < 3; c++) begin
         case (c)
            0: begin bus_sub(32'h700, 32'h1, 32'h2, 64'h3); instr = ADD_A0; end
            1: begin bus_sub(32'h704, 32'h1, 32'h2, 64'h3); instr_rdy = 1'b0; end
            default: begin bus_sub(32'h708, 32'h1, 32'h2, 64'h3); instr_vld = 1'b0; end
         endcase
         tick();
         n_vec++;
         if (rec_cnt !== 3'd0 || rd_vld !== 1'b0 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL nomatch_%0d: cnt=%0d vld=%b drop=%0d, required 0 0 0", c, rec_cnt, rd_vld, drop_cnt);
         end
      end
      bus_idle();
      instr_rdy = 1'b1;
   endtask

   task automatic test_backpressure();
      rd_rdy = 1'b0;
      bus_key(32'h300);
      tick();
      bus_idle();
      for (int s = 0; s < 10; s++) begin
         n_vec++;
         if (rd_vld !== 1'b1 || rd_data !== 32'h300 || rd_idx !== 3'd0 || rd_last !== 1'b0) begin
            n_err++;
            $display("FAIL stall_%0d: vld=%b data=%h idx=%0d last=%b, required 1 00000300 0 0",
                     s, rd_vld, rd_data, rd_idx, rd_last);
         end
         tick();
      end
      rd_rdy = 1'b1;
      for (int w = 0; w < 5; w++) begin
         n_vec++;
         if (rd_vld !== 1'b1 || rd_data !== kw(32'h300, w) || rd_idx !== w[2:0] || rd_last !== (w == 4)) begin
            n_err++;
            $display("FAIL bp_w%0d: vld=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                     w, rd_vld, rd_data, rd_idx, rd_last, kw(32'h300, w), w, (w == 4));
         end
         tick();
      end
      n_vec++;
      if (rd_vld !== 1'b0) begin
         n_err++;
         $display("FAIL bp_post: vld=%b, required 0", rd_vld);
      end
   endtask

   task automatic test_overflow();
      rd_rdy = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         bus_key(32'(k * 16));
         tick();
      end
      bus_idle();
      n_vec++;
      if (rec_cnt !== 3'd4 || drop_cnt !== 8'd2 || rd_vld !== 1'b1) begin
         n_err++;
         $display("FAIL ovf_cnt: cnt=%0d drop=%0d vld=%b, required 4 2 1", rec_cnt, drop_cnt, rd_vld);
      end
      rd_rdy = 1'b1;
      for (int r = 1; r <= 4; r++) begin
         for (int w = 0; w < 5; w++) begin
            n_vec++;
            if (rd_vld !== 1'b1 || rd_data !== kw(32'(r * 16), w) || rd_idx !== w[2:0] || rd_last !== (w == 4)) begin
               n_err++;
               $display("FAIL ovf_r%0d_w%0d: vld=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                        r, w, rd_vld, rd_data, rd_idx, rd_last, kw(32'(r * 16), w), w, (w == 4));
            end
            tick();
         end
      end
      n_vec++;
      if (rd_vld !== 1'b0 || rec_cnt !== 3'd0 || drop_cnt !== 8'd2) begin
         n_err++;
         $display("FAIL ovf_post: vld=%b cnt=%0d drop=%0d, required 0 0 2", rd_vld, rec_cnt, drop_cnt);
      end
   endtask

   task automatic test_full_pop();
      logic [31:0] keys [4];
      keys = '{32'hB0, 32'hC0, 32'hD0, 32'hE0};
      rd_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus_key(32'hA0 + 32'(k * 16));
         tick();
      end
      bus_idle();
      rd_rdy = 1'b1;
      for (int w = 0; w < 4; w++) tick();
      n_vec++;
      if (rd_idx !== 3'd4 || rec_cnt !== 3'd4 || rd_data !== kw(32'hA0, 4)) begin
         n_err++;
         $display("FAIL fp_pre: idx=%0d cnt=%0d data=%h, required 4 4 %h", rd_idx, rec_cnt, rd_data, kw(32'hA0, 4));
      end
      bus_key(32'hE0);
      tick();
      bus_idle();
      n_vec++;
      if (rec_cnt !== 3'd4 || drop_cnt !== 8'd2 || rd_idx !== 3'd0) begin
         n_err++;
         $display("FAIL fp_cnt: cnt=%0d drop=%0d idx=%0d, required 4 2 0", rec_cnt, drop_cnt, rd_idx);
      end
      for (int r = 0; r < 4; r++) begin
         for (int w = 0; w < 5; w++) begin
            n_vec++;
            if (rd_vld !== 1'b1 || rd_data !== kw(keys[r], w) || rd_last !== (w == 4)) begin
               n_err++;
               $display("FAIL fp_r%0d_w%0d: vld=%b data=%h last=%b, required 1 %h %b",
                        r, w, rd_vld, rd_data, rd_last, kw(keys[r], w), (w == 4));
            end
            tick();
         end
      end
      n_vec++;
      if (rd_vld !== 1'b0 || rec_cnt !== 3'd0) begin
         n_err++;
         $display("FAIL fp_post: vld=%b cnt=%0d, required 0 0", rd_vld, rec_cnt);
      end
   endtask

   task automatic test_reset_mid();
      rd_rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         bus_key(32'h500 + 32'(k * 16));
         tick();
      end
      bus_idle();
      rd_rdy = 1'b1;
      tick();
      tick();
      n_vec++;
      if (rd_idx !== 3'd2 || rec_cnt !== 3'd3) begin
         n_err++;
         $display("FAIL rm_pre: idx=%0d cnt=%0d, required 2 3", rd_idx, rec_cnt);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (rd_vld !== 1'b0 || rec_cnt !== 3'd0 || drop_cnt !== 8'd0 || rd_idx !== 3'd0 ||
          rd_data !== 32'h0 || rd_last !== 1'b0) begin
         n_err++;
         $display("FAIL rm_async: vld=%b cnt=%0d drop=%0d idx=%0d data=%h last=%b, required all zero",
                  rd_vld, rec_cnt, drop_cnt, rd_idx, rd_data, rd_last);
      end
      tick();
      rst_n = 1'b1;
      tick();
      bus_key(32'h600);
      tick();
      bus_idle();
      for (int w = 0; w < 5; w++) begin
         n_vec++;
         if (rd_vld !== 1'b1 || rd_data !== kw(32'h600, w) || rd_idx !== w[2:0] || rd_last !== (w == 4)) begin
            n_err++;
            $display("FAIL rm_w%0d: vld=%b data=%h idx=%0d last=%b, required 1 %h %0d %b",
                     w, rd_vld, rd_data, rd_idx, rd_last, kw(32'h600, w), w, (w == 4));
         end
         tick();
      end
      n_vec++;
      if (rd_vld !== 1'b0 || rec_cnt !== 3'd0) begin
         n_err++;
         $display("FAIL rm_post: vld=%b cnt=%0d, required 0 0", rd_vld, rec_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_nomatch();
      test_backpressure();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scr1_sub_trace_buf.md
# scr1_sub_trace_buf

Synthesizable capture-and-readout buffer on the IFU→IDU instruction handshake. On every accepted SUB instruction it records a snapshot of pc, mstatus, mtvec and mcycle into a small FIFO. A valid/ready port streams each snapshot out as 32-bit words, so the same CSR trace can be read in silicon or by a bench consumer instead of being printed.

## Interface
- DEPTH, 4, number of snapshot records held; power of two, ≥2
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_vld  in  1  IFU→IDU instruction valid
- instr_rdy  in  1  IDU ready; instruction accepted when instr_vld & instr_rdy
- instr  in  32  instruction word on IFU→IDU bus
- pc  in  32  pc of the instruction on the bus
- csr_mstatus  in  32  current mstatus
- csr_mtvec  in  32  current mtvec
- csr_mcycle  in  64  current mcycle
- rd_vld  out  1  readout word valid
- rd_rdy  in  1  readout consumer ready
- rd_data  out  32  readout word
- rd_idx  out  3  word index within record, 0..4
- rd_last  out  1  high with word 4 of a record
- rec_cnt  out  $clog2(DEPTH)+1  records currently stored
- drop_cnt  out  8  records dropped due to full buffer, saturating

## Operation
- Match: instr[6:0]=7'b0110011, instr[14:12]=3'b000, instr[31:25]=7'b0100000, all qualified by instr_vld & instr_rdy. No match without the handshake.
- Capture: on match, the record {pc, mstatus, mtvec, mcycle[31:0], mcycle[63:32]} is sampled in that cycle and written at the tail pointer.
- Record word order on readout: idx0=pc, idx1=mstatus, idx2=mtvec, idx3=mcycle[31:0], idx4=mcycle[63:32].
- FIFO uses head/tail pointers of width $clog2(DEPTH)+1 and wraps modulo DEPTH.
  - Empty when the pointers are equal.
  - Full when rec_cnt==DEPTH.
- Push is allowed when rec_cnt<DEPTH, or when a pop of word 4 occurs in the same cycle.
- Otherwise the match is dropped and drop_cnt increments. drop_cnt saturates at 8'hFF.
- Readout FSM:
  - IDLE: rd_vld=0. Moves to SEND when rec_cnt>0.
  - SEND: rd_vld=1 and rd_data = head record word rd_idx.
    - On rd_vld & rd_rdy with rd_idx<4: rd_idx increments.
    - On handshake with rd_idx==4: the head is popped and rd_idx returns to 0. The FSM stays in SEND if records remain, else returns to IDLE.
- While rd_vld=1 and rd_rdy=0, rd_data, rd_idx and rd_last hold stable. The head entry is never overwritten by a push.
- rd_data=0 when rd_vld=0.
- Simultaneous push and pop: rec_cnt is unchanged. Both pointers advance.
- Reset, asynchronous, including mid-record:
  - rec_cnt, pointers, rd_idx and drop_cnt are cleared; the FSM returns to IDLE.
  - Any partial readout is discarded.
  - Outputs: rd_vld=0, rd_data=0, rd_idx=0, rd_last=0, rec_cnt=0, drop_cnt=0.

## Timing
- Capture into FIFO on the clock edge that ends the handshake cycle.
- rec_cnt reflects the new record 1 cycle after the match cycle. rd_vld rises in the same cycle when previously in IDLE, so capture-to-first-word latency is 1 cycle.
- Back-to-back readout with rd_rdy held high: one word per cycle, 5 cycles per record, no bubble between records.
- Matches on consecutive cycles are each captured, one record per cycle.
- rd_last = rd_vld & (rd_idx==4), combinational from state.
- No combinational path from rd_rdy to rd_vld. rd_data depends only on registered state and FIFO storage.

## Test plan
- Single SUB: instr=32'h40B50533 (sub a0,a0,a1), pc=32'h200, mstatus=32'h1880, mtvec=32'h1C0, mcycle=64'h0000_0001_0000_0010, rd_rdy=1.
  - Required: starting the next cycle, 5 words 0x200, 0x1880, 0x1C0, 0x10, 0x1.
  - rd_last on the 5th word; rec_cnt returns to 0.
- Non-matching and unqualified instructions: ADD 32'h00B50533, or SUB with instr_rdy=0.
  - Required: no capture; rec_cnt=0; rd_vld=0.
- Backpressure: one record captured, rd_rdy=0 for 10 cycles then 1.
  - Required: rd_vld=1 and word 0 stable through the stall, then 5 words in order.
- Overflow, DEPTH=4, rd_rdy=0: 6 SUBs with pc=0x10..0x60 step 0x10.
  - Required: rec_cnt=4, drop_cnt=2.
  - With rd_rdy=1, records read out with pc 0x10, 0x20, 0x30, 0x40.
- Full with simultaneous pop: buffer full, SUB accepted in the same cycle as word-4 handshake.
  - Required: record kept, rec_cnt stays 4, drop_cnt unchanged.
- Reset mid-record: rst_n low while rd_idx=2 with 3 records stored.
  - Required: immediately rd_vld=0, rec_cnt=0, drop_cnt=0.
  - After release, a new SUB reads out starting at idx 0.
